// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage between the EX/MEM latch and mem_ctrl.
// Non-memory ops pass their ALU result to write-back in one cycle. Loads and
// stores are latched, issued to mem_ctrl, and held with stall_req until
// mem_ctrl reports DONE. Load data is sign- or zero-extended before write-back.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    // EX/MEM latch
    input  logic [1:0]        in_mem_op,
    input  logic [2:0]        in_funct3,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_we,
    // mem_ctrl data port
    output logic [2:0]        rw_mem,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_quantity,
    input  logic [1:0]        status_mem,
    input  logic [DATA_W-1:0] mem_rdata,
    // pipeline control
    output logic              stall_req,
    // MEM/WB latch
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } mem_op_e;

    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [2:0] RW_OFF   = 3'd0;
    localparam logic [2:0] RW_READ  = 3'd1;
    localparam logic [2:0] RW_WRITE = 3'd2;

    // Registered state
    state_e            state_q,  state_d;
    mem_op_e           op_q,     op_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] sdata_q,  sdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q,     rd_d;
    logic              rd_we_q,  rd_we_d;
    logic              wb_we_q,  wb_we_d;
    logic [4:0]        wb_rd_q,  wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic in_is_mem;
    logic mem_done;

    assign in_is_mem = (in_mem_op == OP_LOAD) || (in_mem_op == OP_STORE);
    assign mem_done  = (status_mem == ST_DONE);

    // Sign/zero extension of returned load data selected by funct3.
    function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] f3,
                                                      input logic [DATA_W-1:0] d);
        case (f3)
            3'b000:  return {{(DATA_W-8){d[7]}}, d[7:0]};    // LB
            3'b001:  return {{(DATA_W-16){d[15]}}, d[15:0]}; // LH
            3'b100:  return {{(DATA_W-8){1'b0}}, d[7:0]};    // LBU
            3'b101:  return {{(DATA_W-16){1'b0}}, d[15:0]};  // LHU
            default: return d;                               // LW, x11
        endcase
    endfunction

    // Request to mem_ctrl: must drop in the DONE cycle, so it is decoded
    // from state and status rather than registered.
    always_comb begin
        rw_mem = RW_OFF;
        if (state_q == S_WAIT && !mem_done) begin
            if (op_q == OP_LOAD)       rw_mem = RW_READ;
            else if (op_q == OP_STORE) rw_mem = RW_WRITE;
        end
    end

    // Upstream hold: raised as soon as a memory op appears, released in the
    // DONE cycle so upstream advances on that edge. Reset forces it low even
    // while the EX/MEM latch still presents a memory op.
    always_comb begin
        stall_req = 1'b0;
        if (rst) begin
            if (state_q == S_IDLE) stall_req = in_is_mem;
            else                   stall_req = !mem_done;
        end
    end

    // Byte quantity from the latched access width.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   mem_quantity = 4'd1;
            2'b01:   mem_quantity = 4'd2;
            default: mem_quantity = 4'd4;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = sdata_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;

    // Next-state logic for the stage FSM, latched request and write-back.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement leaves one unassigned, which would infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        sdata_d   = sdata_q;
        funct3_d  = funct3_q;
        rd_d      = rd_q;
        rd_we_d   = rd_we_q;
        wb_we_d   = wb_we_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;

        case (state_q)
            S_IDLE: begin
                if (in_is_mem) begin
                    op_d     = mem_op_e'(in_mem_op);
                    addr_d   = in_alu_result[ADDR_W-1:0];
                    sdata_d  = in_store_data;
                    funct3_d = in_funct3;
                    rd_d     = in_rd;
                    rd_we_d  = in_rd_we;
                    wb_we_d  = 1'b0;
                    state_d  = S_WAIT;
                end else begin
                    wb_we_d   = in_rd_we;
                    wb_rd_d   = in_rd;
                    wb_data_d = in_alu_result;
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    state_d = S_IDLE;
                    if (op_q == OP_LOAD) begin
                        wb_we_d   = rd_we_q;
                        wb_rd_d   = rd_q;
                        wb_data_d = load_extend(funct3_q, mem_rdata);
                    end else begin
                        wb_we_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; everything holds while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: all registers here are control/data flops (no memory
            // arrays), so each gets a defined reset value.
            state_q   <= S_IDLE;
            op_q      <= OP_NONE;
            addr_q    <= '0;
            sdata_q   <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            rd_we_q   <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else if (rdy) begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            sdata_q   <= sdata_d;
            funct3_q  <= funct3_d;
            rd_q      <= rd_d;
            rd_we_q   <= rd_we_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

endmodule
